// File: rtl/dpi_stream_ctx_pkg.sv
// Shared types and helpers for the per-stream regex context manager.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dpi_pkg;

  // Default widths; the top module exposes each as an overridable parameter.
  localparam int SID_W   = 6;
  localparam int STATE_W = 8;
  localparam int SPEC_W  = 8;
  localparam int CNT_W   = 16;

  // Packet FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    COMMIT = 3'd4
  } dpi_ctx_state_t;

  // Unsigned add that clamps to 2**w-1. Operands are zero-extended to 32 bits
  // by the caller and the result is truncated back to w bits; w must be <= 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      sum = lim;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/dpi_stream_ctx_engine.sv
// Single regex engine: substring matcher for "abc" with loadable progress state.
// Latency: accept_out is registered, one cycle after the completing byte.
// Backpressure: none; consumes a byte every cycle char_in_vld is high.
module dpi_regex_engine #(
  parameter int STATE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_in_vld,
  output logic [STATE_W-1:0] state_out,
  output logic               accept_out
);

  // Match progress: nothing seen, "a" seen, "ab" seen. Unknown loaded values
  // behave as "nothing seen".
  localparam logic [STATE_W-1:0] S_NONE = '0;
  localparam logic [STATE_W-1:0] S_A    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_AB   = STATE_W'(2);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               accept_q;
  logic               hit_d;

  // Next progress and match detection for the incoming byte.
  always_comb begin
    state_d = S_NONE;
    hit_d   = 1'b0;
    if (char_in == 8'h61) begin
      state_d = S_A;
    end else if (char_in == 8'h62 && state_q == S_A) begin
      state_d = S_AB;
    end else if (char_in == 8'h63 && state_q == S_AB) begin
      hit_d = 1'b1;
    end
  end

  // Context load has priority over byte processing; accept is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      if (state_in_vld) begin
        state_q <= state_in;
      end else if (char_in_vld) begin
        state_q  <= state_d;
        accept_q <= hit_d;
      end
    end
  end

  assign state_out  = state_q;
  assign accept_out = accept_q;

endmodule

// File: rtl/dpi_stream_ctx.sv
// Per-stream regex context manager: restore, speculate, commit/discard per packet.
// Latency: sop->RUN 2 cycles; eop->memories updated 3 cycles; rd_count 1 cycle.
// Backpressure: in_ready high only in RUN; inputs arriving elsewhere raise err.
module dpi_stream_ctx #(
  parameter int SID_W   = dpi_pkg::SID_W,
  parameter int STATE_W = dpi_pkg::STATE_W,
  parameter int SPEC_W  = dpi_pkg::SPEC_W,
  parameter int CNT_W   = dpi_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sop,
  input  logic [SID_W-1:0] stream_id,
  input  logic             new_stream,
  input  logic [7:0]       char_in,
  input  logic             char_in_vld,
  input  logic             eop,
  input  logic             enable,
  input  logic [SID_W-1:0] rd_sid,
  output logic             in_ready,
  output logic             busy,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] rd_count,
  output logic             commit_vld,
  output logic [SID_W-1:0] commit_sid,
  output logic             err
);

  import dpi_pkg::*;

  localparam int NSTREAM = 1 << SID_W;

  dpi_ctx_state_t     state_q;
  logic [SID_W-1:0]   sid_q;
  logic               new_q;
  logic               en_q;
  logic [SPEC_W-1:0]  spec_q;
  logic [CNT_W-1:0]   total_q;
  logic [NSTREAM-1:0] valid_q;
  logic [CNT_W-1:0]   rd_count_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               commit_vld_q;
  logic [SID_W-1:0]   commit_sid_q;
  logic               err_q;

  // Context memories: one write port, no reset. valid_q masks stale contents,
  // so a cleared valid bit reads as count 0 and state 0.
  logic [STATE_W-1:0] state_mem [NSTREAM];
  logic [CNT_W-1:0]   cnt_mem   [NSTREAM];

  logic               eng_char_vld;
  logic               eng_state_in_vld;
  logic [STATE_W-1:0] eng_state_in;
  logic [STATE_W-1:0] eng_state_out;
  logic               eng_accept;
  logic               violation;
  logic               commit_upd;
  logic [CNT_W-1:0]   cnt_cur;

  assign eng_char_vld     = (state_q == RUN) && char_in_vld;
  assign eng_state_in_vld = (state_q == LOAD);
  assign eng_state_in     = (new_q || !valid_q[sid_q]) ? '0 : state_mem[sid_q];
  assign commit_upd       = (state_q == COMMIT) && en_q;
  assign cnt_cur          = valid_q[sid_q] ? cnt_mem[sid_q] : '0;

  assign violation = (sop && state_q != IDLE) ||
                     (eop && state_q != RUN) ||
                     (char_in_vld && state_q != RUN);

  dpi_regex_engine #(
    .STATE_W (STATE_W)
  ) u_engine (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in      (char_in),
    .char_in_vld  (eng_char_vld),
    .state_in     (eng_state_in),
    .state_in_vld (eng_state_in_vld),
    .state_out    (eng_state_out),
    .accept_out   (eng_accept)
  );

  // Packet FSM with registered handshake, busy, commit and error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sid_q        <= '0;
      new_q        <= 1'b0;
      en_q         <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      commit_vld_q <= 1'b0;
      commit_sid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q        <= violation;
      commit_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sop) begin
            sid_q   <= stream_id;
            new_q   <= new_stream;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          in_ready_q <= 1'b1;
          state_q    <= RUN;
        end
        RUN: begin
          if (eop) begin
            en_q       <= enable;
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          // Pulse lands in the COMMIT cycle.
          commit_vld_q <= en_q;
          if (en_q) begin
            commit_sid_q <= sid_q;
          end
          state_q <= COMMIT;
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Speculative per-packet match count; cleared while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_q <= '0;
    end else if (state_q == IDLE) begin
      spec_q <= '0;
    end else if ((state_q == RUN || state_q == DRAIN) && eng_accept) begin
      spec_q <= SPEC_W'(sat_add(32'(spec_q), 32'd1, SPEC_W));
    end
  end

  // Committed total and per-stream valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q <= '0;
      valid_q <= '0;
    end else if (commit_upd) begin
      total_q        <= CNT_W'(sat_add(32'(total_q), 32'(spec_q), CNT_W));
      valid_q[sid_q] <= 1'b1;
    end
  end

  // Context memory write on an enabled commit.
  always_ff @(posedge clk) begin
    if (commit_upd) begin
      state_mem[sid_q] <= eng_state_out;
      cnt_mem[sid_q]   <= CNT_W'(sat_add(32'(cnt_cur), 32'(spec_q), CNT_W));
    end
  end

  // Registered count read-back; sees the pre-write value during a same-sid commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q <= '0;
    end else begin
      rd_count_q <= valid_q[rd_sid] ? cnt_mem[rd_sid] : '0;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign total_count = total_q;
  assign rd_count    = rd_count_q;
  assign commit_vld  = commit_vld_q;
  assign commit_sid  = commit_sid_q;
  assign err         = err_q;

endmodule
